// File: rtl/adder_axi_control_slave.sv
// AXI4-Lite control slave for the adder kernel: holds the kernel arguments,
// drives ap_start and reports done/idle/ready status plus the interrupt.
module adder_axi_control_slave #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  S_AXI_CONTROL_AWVALID,
  output logic                  S_AXI_CONTROL_AWREADY,
  input  logic [63:0]           S_AXI_CONTROL_AWADDR,
  input  logic [2:0]            S_AXI_CONTROL_AWPROT,
  input  logic                  S_AXI_CONTROL_WVALID,
  output logic                  S_AXI_CONTROL_WREADY,
  input  logic [DATA_W-1:0]     S_AXI_CONTROL_WDATA,
  input  logic [DATA_W/8-1:0]   S_AXI_CONTROL_WSTRB,
  output logic                  S_AXI_CONTROL_BVALID,
  input  logic                  S_AXI_CONTROL_BREADY,
  output logic [1:0]            S_AXI_CONTROL_BRESP,
  input  logic                  S_AXI_CONTROL_ARVALID,
  output logic                  S_AXI_CONTROL_ARREADY,
  input  logic [63:0]           S_AXI_CONTROL_ARADDR,
  input  logic [2:0]            S_AXI_CONTROL_ARPROT,
  output logic                  S_AXI_CONTROL_RVALID,
  input  logic                  S_AXI_CONTROL_RREADY,
  output logic [DATA_W-1:0]     S_AXI_CONTROL_RDATA,
  output logic [1:0]            S_AXI_CONTROL_RRESP,
  output logic                  ap_start,
  input  logic                  ap_done,
  input  logic                  ap_idle,
  input  logic                  ap_ready,
  output logic [63:0]           arg_a,
  output logic [63:0]           arg_b,
  output logic [63:0]           arg_c,
  output logic [31:0]           arg_len,
  output logic                  interrupt
);

  localparam logic [ADDR_W-1:0] A_CTRL    = ADDR_W'(6'h00);
  localparam logic [ADDR_W-1:0] A_GIE     = ADDR_W'(6'h04);
  localparam logic [ADDR_W-1:0] A_IER     = ADDR_W'(6'h08);
  localparam logic [ADDR_W-1:0] A_ISR     = ADDR_W'(6'h0C);
  localparam logic [ADDR_W-1:0] A_ARGA_LO = ADDR_W'(6'h10);
  localparam logic [ADDR_W-1:0] A_ARGA_HI = ADDR_W'(6'h14);
  localparam logic [ADDR_W-1:0] A_ARGB_LO = ADDR_W'(6'h1C);
  localparam logic [ADDR_W-1:0] A_ARGB_HI = ADDR_W'(6'h20);
  localparam logic [ADDR_W-1:0] A_ARGC_LO = ADDR_W'(6'h28);
  localparam logic [ADDR_W-1:0] A_ARGC_HI = ADDR_W'(6'h2C);
  localparam logic [ADDR_W-1:0] A_LEN     = ADDR_W'(6'h34);

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
  typedef enum logic       {RIDLE, RDATA}        rstate_t;

  wstate_t r_wstate, w_wstate_next;
  rstate_t r_rstate, w_rstate_next;

  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_rdata, w_rdata_mux;
  logic              r_ap_start, r_done, r_auto_restart, r_gie, r_irq;
  logic [1:0]        r_ier, r_isr, w_isr_next;
  logic [63:0]       r_arg_a, r_arg_b, r_arg_c;
  logic [31:0]       r_arg_len;

  logic              w_wr, w_rd;
  logic [ADDR_W-1:0] w_raddr;
  logic              w_unused_ok;

  assign w_unused_ok = ^{S_AXI_CONTROL_AWPROT, S_AXI_CONTROL_ARPROT,
                         S_AXI_CONTROL_AWADDR[63:ADDR_W], S_AXI_CONTROL_ARADDR[63:ADDR_W]};

  assign w_wr    = S_AXI_CONTROL_WVALID  && (r_wstate == WDATA);
  assign w_rd    = S_AXI_CONTROL_ARVALID && (r_rstate == RIDLE);
  assign w_raddr = S_AXI_CONTROL_ARADDR[ADDR_W-1:0];

  function automatic logic [31:0] f_mask(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Write channel FSM
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_wstate <= WIDLE;
      r_waddr  <= '0;
    end else begin
      r_wstate <= w_wstate_next;
      if (r_wstate == WIDLE && S_AXI_CONTROL_AWVALID) r_waddr <= S_AXI_CONTROL_AWADDR[ADDR_W-1:0];
    end
  end

  always_comb begin
    w_wstate_next = r_wstate;
    case (r_wstate)
      WIDLE:   if (S_AXI_CONTROL_AWVALID) w_wstate_next = WDATA;
      WDATA:   if (S_AXI_CONTROL_WVALID)  w_wstate_next = WRESP;
      WRESP:   if (S_AXI_CONTROL_BREADY)  w_wstate_next = WIDLE;
      default: w_wstate_next = WIDLE;
    endcase
  end

  always_comb begin
    S_AXI_CONTROL_AWREADY = (r_wstate == WIDLE);
    S_AXI_CONTROL_WREADY  = (r_wstate == WDATA);
    S_AXI_CONTROL_BVALID  = (r_wstate == WRESP);
    S_AXI_CONTROL_BRESP   = 2'b00;
  end

  // Read channel FSM
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_rstate <= RIDLE;
      r_rdata  <= '0;
    end else begin
      r_rstate <= w_rstate_next;
      if (w_rd) r_rdata <= w_rdata_mux;
    end
  end

  always_comb begin
    w_rstate_next = r_rstate;
    case (r_rstate)
      RIDLE:   if (S_AXI_CONTROL_ARVALID) w_rstate_next = RDATA;
      RDATA:   if (S_AXI_CONTROL_RREADY)  w_rstate_next = RIDLE;
      default: w_rstate_next = RIDLE;
    endcase
  end

  always_comb begin
    S_AXI_CONTROL_ARREADY = (r_rstate == RIDLE);
    S_AXI_CONTROL_RVALID  = (r_rstate == RDATA);
    S_AXI_CONTROL_RDATA   = r_rdata;
    S_AXI_CONTROL_RRESP   = 2'b00;
  end

  always_comb begin
    w_rdata_mux = '0;
    case (w_raddr)
      A_CTRL:    w_rdata_mux = {24'd0, r_auto_restart, 3'd0, ap_ready, ap_idle, r_done, r_ap_start};
      A_GIE:     w_rdata_mux = {31'd0, r_gie};
      A_IER:     w_rdata_mux = {30'd0, r_ier};
      A_ISR:     w_rdata_mux = {30'd0, r_isr};
      A_ARGA_LO: w_rdata_mux = r_arg_a[31:0];
      A_ARGA_HI: w_rdata_mux = r_arg_a[63:32];
      A_ARGB_LO: w_rdata_mux = r_arg_b[31:0];
      A_ARGB_HI: w_rdata_mux = r_arg_b[63:32];
      A_ARGC_LO: w_rdata_mux = r_arg_c[31:0];
      A_ARGC_HI: w_rdata_mux = r_arg_c[63:32];
      A_LEN:     w_rdata_mux = r_arg_len;
      default:   w_rdata_mux = '0;
    endcase
  end

  // Toggle from the host first, then hardware events force bits high so a set wins
  always_comb begin
    w_isr_next = r_isr;
    if (w_wr && r_waddr == A_ISR && S_AXI_CONTROL_WSTRB[0]) w_isr_next = r_isr ^ S_AXI_CONTROL_WDATA[1:0];
    w_isr_next = w_isr_next | {ap_ready & r_ier[1], ap_done & r_ier[0]};
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_ap_start     <= 1'b0;
      r_done         <= 1'b0;
      r_auto_restart <= 1'b0;
      r_gie          <= 1'b0;
      r_ier          <= '0;
      r_isr          <= '0;
      r_irq          <= 1'b0;
      r_arg_a        <= '0;
      r_arg_b        <= '0;
      r_arg_c        <= '0;
      r_arg_len      <= '0;
    end else begin
      if (w_wr) begin
        case (r_waddr)
          A_CTRL:    if (S_AXI_CONTROL_WSTRB[0]) r_auto_restart <= S_AXI_CONTROL_WDATA[7];
          A_GIE:     if (S_AXI_CONTROL_WSTRB[0]) r_gie <= S_AXI_CONTROL_WDATA[0];
          A_IER:     if (S_AXI_CONTROL_WSTRB[0]) r_ier <= S_AXI_CONTROL_WDATA[1:0];
          A_ARGA_LO: r_arg_a[31:0]  <= f_mask(r_arg_a[31:0],  S_AXI_CONTROL_WDATA, S_AXI_CONTROL_WSTRB);
          A_ARGA_HI: r_arg_a[63:32] <= f_mask(r_arg_a[63:32], S_AXI_CONTROL_WDATA, S_AXI_CONTROL_WSTRB);
          A_ARGB_LO: r_arg_b[31:0]  <= f_mask(r_arg_b[31:0],  S_AXI_CONTROL_WDATA, S_AXI_CONTROL_WSTRB);
          A_ARGB_HI: r_arg_b[63:32] <= f_mask(r_arg_b[63:32], S_AXI_CONTROL_WDATA, S_AXI_CONTROL_WSTRB);
          A_ARGC_LO: r_arg_c[31:0]  <= f_mask(r_arg_c[31:0],  S_AXI_CONTROL_WDATA, S_AXI_CONTROL_WSTRB);
          A_ARGC_HI: r_arg_c[63:32] <= f_mask(r_arg_c[63:32], S_AXI_CONTROL_WDATA, S_AXI_CONTROL_WSTRB);
          A_LEN:     r_arg_len      <= f_mask(r_arg_len,      S_AXI_CONTROL_WDATA, S_AXI_CONTROL_WSTRB);
          default: ;
        endcase
      end

      // A host start request takes priority over the ready-driven clear
      if (w_wr && r_waddr == A_CTRL && S_AXI_CONTROL_WSTRB[0] && S_AXI_CONTROL_WDATA[0])
        r_ap_start <= 1'b1;
      else if (ap_ready && !r_auto_restart)
        r_ap_start <= 1'b0;

      if (ap_done)
        r_done <= 1'b1;
      else if (w_rd && w_raddr == A_CTRL)
        r_done <= 1'b0;

      r_isr <= w_isr_next;
      r_irq <= r_gie & (|r_isr);
    end
  end

  assign ap_start  = r_ap_start;
  assign arg_a     = r_arg_a;
  assign arg_b     = r_arg_b;
  assign arg_c     = r_arg_c;
  assign arg_len   = r_arg_len;
  assign interrupt = r_irq;

endmodule

// File: tb/tb_adder_axi_control_slave.sv
// Directed bench for adder_axi_control_slave: register map, start/done
// handshakes, interrupts, channel overlap and asynchronous reset.
module tb_adder_axi_control_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        ap_start, ap_done, ap_idle, ap_ready, interrupt;
  logic [63:0] arg_a, arg_b, arg_c;
  logic [31:0] arg_len;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_axi_control_slave dut (
    .ap_clk(clk), .ap_rst_n(rst_n),
    .S_AXI_CONTROL_AWVALID(awvalid), .S_AXI_CONTROL_AWREADY(awready),
    .S_AXI_CONTROL_AWADDR(awaddr), .S_AXI_CONTROL_AWPROT(awprot),
    .S_AXI_CONTROL_WVALID(wvalid), .S_AXI_CONTROL_WREADY(wready),
    .S_AXI_CONTROL_WDATA(wdata), .S_AXI_CONTROL_WSTRB(wstrb),
    .S_AXI_CONTROL_BVALID(bvalid), .S_AXI_CONTROL_BREADY(bready),
    .S_AXI_CONTROL_BRESP(bresp),
    .S_AXI_CONTROL_ARVALID(arvalid), .S_AXI_CONTROL_ARREADY(arready),
    .S_AXI_CONTROL_ARADDR(araddr), .S_AXI_CONTROL_ARPROT(arprot),
    .S_AXI_CONTROL_RVALID(rvalid), .S_AXI_CONTROL_RREADY(rready),
    .S_AXI_CONTROL_RDATA(rdata), .S_AXI_CONTROL_RRESP(rresp),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
    .arg_a(arg_a), .arg_b(arg_b), .arg_c(arg_c), .arg_len(arg_len),
    .interrupt(interrupt)
  );

  // AW and W presented together; held_cycles counts BREADY-low cycles with BVALID=1 and AWREADY=0
  task automatic axi_write(input logic [63:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int bdelay, output logic [1:0] resp, output int held_cycles);
    int n;
    held_cycles = 0;
    resp = 2'b11;
    @(negedge clk);
    awaddr = addr; awvalid = 1'b1; wdata = data; wstrb = strb; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    awvalid = 1'b0;
    n = 0;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!bvalid) begin
      errors++;
      $display("FAIL write_timeout addr=%h bvalid=%b required=1", addr, bvalid);
    end
    resp = bresp;
    for (int i = 0; i < bdelay; i++) begin
      if (bvalid && !awready) held_cycles++;
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    $display("write addr=%h data=%h strb=%h bresp=%0d", addr, data, strb, resp);
  endtask

  // valid_next records RVALID on the negedge right after the AR handshake
  task automatic axi_read(input logic [63:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output logic valid_next);
    int n;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid = 1'b0;
    valid_next = rvalid;
    data = rdata;
    resp = rresp;
    checks++;
    if (!rvalid) begin
      errors++;
      $display("FAIL read_timeout addr=%h rvalid=%b required=1", addr, rvalid);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    $display("read addr=%h data=%h rresp=%0d", addr, data, resp);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    logic        v;
    checks++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_handshake got=%b required=11000", {awready, arready, wready, bvalid, rvalid});
    end
    checks++;
    if ({rdata, ap_start, interrupt} !== 34'd0) begin
      errors++;
      $display("FAIL reset_outputs rdata=%h start=%b irq=%b required=0", rdata, ap_start, interrupt);
    end
    checks++;
    if ({arg_a, arg_b, arg_c, arg_len} !== 224'd0) begin
      errors++;
      $display("FAIL reset_args a=%h b=%h c=%h len=%h required=0", arg_a, arg_b, arg_c, arg_len);
    end
    axi_read(64'h0, d, r, v);
    checks++;
    if (d !== 32'h4 || r !== 2'b00 || v !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl_read data=%h resp=%0d valid=%b required=00000004/0/1", d, r, v);
    end
  endtask

  task automatic test_args();
    logic [1:0] resp;
    int         held;
    axi_write(64'h10, 32'hDEADBEEF, 4'hF, 0, resp, held);
    axi_write(64'h14, 32'h00000001, 4'hF, 0, resp, held);
    axi_write(64'h34, 32'h00000100, 4'hF, 0, resp, held);
    checks++;
    if (arg_a !== 64'h00000001DEADBEEF) begin
      errors++;
      $display("FAIL arg_a got=%h required=00000001deadbeef", arg_a);
    end
    checks++;
    if (arg_len !== 32'h100) begin
      errors++;
      $display("FAIL arg_len got=%h required=00000100", arg_len);
    end
    axi_write(64'h34, 32'hFFFFFFFF, 4'h2, 0, resp, held);
    checks++;
    if (arg_len !== 32'h0000FF00) begin
      errors++;
      $display("FAIL arg_len_strb got=%h required=0000ff00", arg_len);
    end
    axi_write(64'h2C, 32'hCAFEF00D, 4'hF, 0, resp, held);
    axi_write(64'h20, 32'h00000055, 4'h1, 0, resp, held);
    checks++;
    if (arg_c !== 64'hCAFEF00D00000000 || arg_b !== 64'h0000005500000000) begin
      errors++;
      $display("FAIL arg_bc b=%h c=%h required=0000005500000000/cafef00d00000000", arg_b, arg_c);
    end
  endtask

  task automatic test_ap_start();
    logic [1:0] resp;
    int         held;
    axi_write(64'h0, 32'h1, 4'hF, 0, resp, held);
    checks++;
    if (ap_start !== 1'b1) begin
      errors++;
      $display("FAIL start_set got=%b required=1", ap_start);
    end
    axi_write(64'h0, 32'h0, 4'hF, 0, resp, held);
    checks++;
    if (ap_start !== 1'b1) begin
      errors++;
      $display("FAIL start_write0_keeps got=%b required=1", ap_start);
    end
    ap_ready = 1'b1;
    @(negedge clk);
    ap_ready = 1'b0;
    checks++;
    if (ap_start !== 1'b0) begin
      errors++;
      $display("FAIL start_clear_on_ready got=%b required=0", ap_start);
    end
    axi_write(64'h0, 32'h81, 4'hF, 0, resp, held);
    ap_ready = 1'b1;
    @(negedge clk);
    ap_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ap_start !== 1'b1) begin
      errors++;
      $display("FAIL start_auto_restart got=%b required=1", ap_start);
    end
    axi_write(64'h0, 32'h0, 4'hF, 0, resp, held);
    ap_ready = 1'b1;
    @(negedge clk);
    ap_ready = 1'b0;
    checks++;
    if (ap_start !== 1'b0) begin
      errors++;
      $display("FAIL start_clear_after_auto_off got=%b required=0", ap_start);
    end
  endtask

  task automatic test_interrupt();
    logic [1:0]  resp;
    int          held;
    logic [31:0] d;
    logic        v;
    axi_write(64'h4, 32'h1, 4'hF, 0, resp, held);
    axi_write(64'h8, 32'h1, 4'hF, 0, resp, held);
    ap_done = 1'b1;
    @(negedge clk);
    ap_done = 1'b0;
    @(negedge clk);
    checks++;
    if (interrupt !== 1'b1) begin
      errors++;
      $display("FAIL irq_raise got=%b required=1", interrupt);
    end
    axi_read(64'h0, d, resp, v);
    checks++;
    if (d !== 32'h6) begin
      errors++;
      $display("FAIL ctrl_done_read got=%h required=00000006", d);
    end
    axi_read(64'h0, d, resp, v);
    checks++;
    if (d !== 32'h4) begin
      errors++;
      $display("FAIL ctrl_done_cleared got=%h required=00000004", d);
    end
    axi_read(64'hC, d, resp, v);
    checks++;
    if (d !== 32'h1) begin
      errors++;
      $display("FAIL isr_read got=%h required=00000001", d);
    end
    axi_write(64'hC, 32'h1, 4'hF, 0, resp, held);
    checks++;
    if (interrupt !== 1'b0) begin
      errors++;
      $display("FAIL irq_clear_w1t got=%b required=0", interrupt);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  wresp, rresp_l;
    int          held;
    logic [31:0] d;
    logic        v;
    fork
      axi_write(64'h28, 32'h12345678, 4'hF, 5, wresp, held);
      axi_read(64'h2C, d, rresp_l, v);
    join
    checks++;
    if (held !== 5) begin
      errors++;
      $display("FAIL bvalid_hold got=%0d required=5", held);
    end
    checks++;
    if (wresp !== 2'b00 || awready !== 1'b1) begin
      errors++;
      $display("FAIL b_done bresp=%0d awready=%b required=0/1", wresp, awready);
    end
    checks++;
    if (d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL overlap_read got=%h required=cafef00d", d);
    end
    checks++;
    if (arg_c !== 64'hCAFEF00D12345678) begin
      errors++;
      $display("FAIL overlap_arg_c got=%h required=cafef00d12345678", arg_c);
    end
  endtask

  task automatic test_reset_abort();
    logic [1:0]  resp;
    int          held;
    logic [31:0] d;
    logic        v;
    axi_write(64'h0, 32'h1, 4'hF, 0, resp, held);
    @(negedge clk);
    awaddr = 64'h10; awvalid = 1'b1; wdata = 32'h1111; wstrb = 4'hF; wvalid = 1'b0;
    @(negedge clk);
    awvalid = 1'b0;
    checks++;
    if (wready !== 1'b1) begin
      errors++;
      $display("FAIL abort_wdata_state wready=%b required=1", wready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({awready, wready, bvalid, ap_start} !== 4'b1000 || arg_a !== 64'd0) begin
      errors++;
      $display("FAIL abort_write aw/w/b/start=%b arg_a=%h required=1000/0", {awready, wready, bvalid, ap_start}, arg_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    araddr = 64'h0; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1 || rdata !== 32'h4) begin
      errors++;
      $display("FAIL abort_rdata_state rvalid=%b rdata=%h required=1/00000004", rvalid, rdata);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b1 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL abort_read rvalid=%b arready=%b rdata=%h required=0/1/0", rvalid, arready, rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    axi_write(64'h3C, 32'hFFFFFFFF, 4'hF, 0, resp, held);
    checks++;
    if (resp !== 2'b00 || {arg_a, arg_b, arg_c, arg_len, ap_start} !== 225'd0) begin
      errors++;
      $display("FAIL unmapped_write bresp=%0d a=%h b=%h c=%h len=%h required=0 and zero regs",
               resp, arg_a, arg_b, arg_c, arg_len);
    end
    axi_read(64'h3C, d, resp, v);
    checks++;
    if (d !== 32'd0 || resp !== 2'b00) begin
      errors++;
      $display("FAIL unmapped_read data=%h resp=%0d required=0/0", d, resp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    ap_done = 1'b0; ap_idle = 1'b1; ap_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_args();
    test_ap_start();
    test_interrupt();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
